program_loader_ram: RTL
=======================

PROGRAM_LOADER_RAM -- requirements
Module: program_loader_ram

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5, meaning word-address width (depth = 2^ADDR_WIDTH words, 32 words at default).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning word width, fixed at 32 (4 bytes per word).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load_start  input  1  single-cycle pulse that begins a program load.
REQ-006 byte_in  input  8  program byte stream data.
REQ-007 byte_valid  input  1  byte_in holds a valid byte.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 load_busy  output  1  a load is in progress.
REQ-010 load_done  output  1  the full memory has been loaded since the last load_start.
REQ-011 address  input  ADDR_WIDTH  CPU fetch word address.
REQ-012 chip_select  input  1  CPU fetch enable.
REQ-013 data_out  output  32  fetched instruction word.

Function
REQ-014 The block SHALL hold a 2^ADDR_WIDTH x 32 memory and an FSM with states IDLE, LOAD, DONE.
REQ-015 A byte SHALL be accepted on a rising edge where byte_valid=1 and byte_ready=1; byte_ready SHALL equal 1 exactly while state=LOAD.
REQ-016 Bytes SHALL be packed MSB first: the 1st accepted byte of a word goes to [31:24], the 2nd to [23:16], the 3rd to [15:8], the 4th to [7:0].
REQ-017 On the edge accepting the 4th byte, memory[word_addr] SHALL be written with the assembled word; word_addr SHALL increment by one and byte_count SHALL return to 0.
REQ-018 Words SHALL be written to ascending addresses starting at 0; no write SHALL occur outside LOAD.
REQ-019 IDLE -> LOAD SHALL occur on the edge where load_start=1; byte_count and word_addr SHALL clear on that edge, so byte_ready=1 in the following cycle.
REQ-020 LOAD -> DONE SHALL occur on the edge writing word 2^ADDR_WIDTH-1; word_addr SHALL wrap to 0 on that edge.
REQ-021 DONE -> LOAD SHALL occur on load_start=1 (reload) with counters cleared; DONE otherwise SHALL persist.
REQ-022 load_start while in LOAD SHALL be ignored, with no counter reset.
REQ-023 Cycles with byte_valid=0 in LOAD SHALL hold all counters and partial-word bytes unchanged (arbitrary gaps allowed).
REQ-024 load_busy SHALL equal 1 exactly in LOAD; load_done SHALL equal 1 exactly in DONE.
REQ-025 Reads SHALL be combinational: data_out = memory[address] when chip_select=1 and state!=LOAD, otherwise 32'h0000_0000.
REQ-026 A read of any address during LOAD SHALL return 0 regardless of chip_select.
REQ-027 Reads of never-written locations SHALL be unspecified; benches SHALL not check them.

Reset
REQ-028 On a rising edge with reset=1, state SHALL become IDLE and byte_count, word_addr and the partial-word register SHALL clear; reset SHALL take priority over load_start and byte acceptance.
REQ-029 After reset, byte_ready=0, load_busy=0, load_done=0, and data_out=0 when chip_select=0.
REQ-030 Memory contents SHALL NOT be cleared by reset; words written before a mid-load reset SHALL remain readable in IDLE.
REQ-031 A partial word pending at a mid-load reset SHALL be discarded and never written.

Verification
REQ-032 Full load: reset, pulse load_start, stream 128 bytes 00,01,...,7F with valid always high -> load_done=1 one cycle after byte 128; chip_select=1, address=0 -> data_out=32'h00010203; address=31 -> 32'h7C7D7E7F.
REQ-033 Gapped stream: same load with byte_valid toggling 1,0,1,0 -> identical memory contents; load_busy stays 1 throughout LOAD and load_done rises after exactly 128 accepted bytes.
REQ-034 Mid-load reset: load 10 bytes AA..B3, then assert reset for one cycle -> state IDLE, load_done=0; address=0 -> 32'hAAABACAD, address=1 -> 32'hAEAFB0B1; bytes B2 and B3 are discarded.
REQ-035 Ignored restart: pulse load_start after 6 accepted bytes -> next accepted byte completes word 1 as byte 3; total bytes to DONE remain 128.
REQ-036 Read gating: during LOAD with chip_select=1 -> data_out=0; in DONE with chip_select=0 -> data_out=0; in DONE with chip_select=1, address=5 -> the word loaded as bytes 20-23.
REQ-037 Reload: in DONE, pulse load_start and stream 128 bytes of FF -> load_done drops the cycle after load_start, then rises again; every address reads 32'hFFFFFFFF.

Source files
------------

// File: rtl/program_loader_ram.sv
// program_loader_ram: byte-streamed program loader in front of a word RAM.
// Incoming bytes are packed MSB first into 32-bit words and written to
// ascending addresses; the CPU read port is gated off while a load runs.
module program_loader_ram #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  load_busy,
    output logic                  load_done,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  chip_select,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [1:0]            byte_count_q, byte_count_d;
    logic [ADDR_WIDTH-1:0] word_addr_q, word_addr_d;
    // First three bytes of the word being assembled, oldest in [23:16].
    logic [23:0]           partial_q, partial_d;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Next-state logic: FSM, byte packing and word write request.
    always_comb begin
        state_d      = state_q;
        byte_count_d = byte_count_q;
        word_addr_d  = word_addr_q;
        partial_d    = partial_q;
        wr_en        = 1'b0;
        wr_data      = {partial_q, byte_in};
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_start) begin
                    state_d      = ST_LOAD;
                    byte_count_d = '0;
                    word_addr_d  = '0;
                    partial_d    = '0;
                end
            end
            ST_LOAD: begin
                // load_start is deliberately ignored here: no restart mid-load.
                if (byte_valid) begin
                    if (byte_count_q == 2'd3) begin
                        wr_en        = 1'b1;
                        byte_count_d = '0;
                        // Natural wrap to 0 after the last word.
                        word_addr_d  = word_addr_q + 1'b1;
                        if (word_addr_q == {ADDR_WIDTH{1'b1}}) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        byte_count_d = byte_count_q + 1'b1;
                        partial_d    = {partial_q[15:0], byte_in};
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers; reset wins over every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            byte_count_q <= '0;
            word_addr_q  <= '0;
            partial_q    <= '0;
        end else begin
            state_q      <= state_d;
            byte_count_q <= state_q == ST_LOAD ? byte_count_d : byte_count_d;
            word_addr_q  <= word_addr_d;
            partial_q    <= partial_d;
        end
    end

    // Memory array: never cleared by reset, but a reset edge blocks the write.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[word_addr_q] <= wr_data;
        end
    end

    assign byte_ready = (state_q == ST_LOAD);
    assign load_busy  = (state_q == ST_LOAD);
    assign load_done  = (state_q == ST_DONE);

    // Combinational read port, forced to zero while loading or deselected.
    always_comb begin
        data_out = '0;
        if (chip_select && state_q != ST_LOAD) begin
            data_out = mem[address];
        end
    end

endmodule
